// File: rtl/scan_test_pkg.sv
// Shared definitions for the scan pattern applicator: FSM states and
// pattern-word field placement ({stim, exp}, exp in the low half).
package scan_test_pkg;

   localparam int unsigned DEFAULT_CHAIN_LEN = 32;
   localparam int unsigned EXP_LSB           = 0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SHIFT,
      CAPTURE,
      UNLOAD,
      DONE
   } scanState_t;

   function automatic int unsigned expMsb(input int unsigned len);
      return EXP_LSB + len - 1;
   endfunction

   function automatic int unsigned stimLsb(input int unsigned len);
      return EXP_LSB + len;
   endfunction

   function automatic int unsigned stimMsb(input int unsigned len);
      return EXP_LSB + 2 * len - 1;
   endfunction

endpackage

// File: rtl/scan_resp_compare.sv
// Combinational response check: counts bits where the captured response
// differs from the expected response.
module scan_resp_compare #(
   parameter int unsigned CHAIN_LEN = 32,
   parameter int unsigned PC_W      = 6
) (
   input  logic [CHAIN_LEN-1:0] resp,
   input  logic [CHAIN_LEN-1:0] expBits,
   output logic [PC_W-1:0]      popCnt,
   output logic                 anyMismatch
);

   logic [CHAIN_LEN-1:0] diff;

   always_comb begin
      diff   = resp ^ expBits;
      popCnt = '0;
      for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
         popCnt = popCnt + PC_W'(diff[i]);
      end
      anyMismatch = |diff;
   end

endmodule

// File: rtl/scan_pattern_applicator.sv
// Applies stored scan patterns to a full-scan chain: fetch, shift in while
// unloading the previous response, capture, and accumulate mismatch results.
module scan_pattern_applicator
   import scan_test_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                   CK,
   input  logic                   RST,
   input  logic                   start,
   input  logic [ADDR_W:0]        num_pat,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   mem_rd,
   input  logic [2*CHAIN_LEN-1:0] mem_data,
   output logic                   scan_en,
   output logic                   scan_in,
   input  logic                   scan_out,
   output logic                   busy,
   output logic                   done,
   output logic                   fail,
   output logic [CNT_W-1:0]       mismatch_cnt,
   output logic [ADDR_W-1:0]      first_fail
);

   localparam int unsigned STIM_MSB = stimMsb(CHAIN_LEN);
   localparam int unsigned STIM_LSB = stimLsb(CHAIN_LEN);
   localparam int unsigned EXP_MSB  = expMsb(CHAIN_LEN);
   localparam int unsigned BIT_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam int unsigned PC_W     = $clog2(CHAIN_LEN + 1);
   localparam int unsigned SUM_W    = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam int unsigned NP_W     = ADDR_W + 1;
   localparam logic [NP_W-1:0]  MAX_PAT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   scanState_t           state, stateNext;
   logic [ADDR_W-1:0]    patIdx, patIdxNext, cmpIdx, firstFailNext, memAddrNext;
   logic [NP_W-1:0]      numPatR, numPatNext;
   logic [BIT_W-1:0]     bitCnt, bitCntNext;
   logic [CHAIN_LEN-1:0] stimSr, stimSrNext, expCur, expCurNext, expNxt, expNxtNext;
   logic [CHAIN_LEN-2:0] respSr, respSrNext;
   logic [CHAIN_LEN-1:0] respFull;
   logic [CNT_W-1:0]     cntNext;
   logic [SUM_W-1:0]     cntSum;
   logic [PC_W-1:0]      popCnt;
   logic                 anyMismatch, lastBit, doCompare, failNext;
   logic                 memRdNext, scanEnNext, scanInNext, busyNext, doneNext;

   // The bit currently on scan_out completes the response on the final shift edge
   assign respFull = {scan_out, respSr};
   assign lastBit  = (bitCnt == BIT_W'(CHAIN_LEN - 1));
   assign cntSum   = SUM_W'(mismatch_cnt) + SUM_W'(popCnt);

   scan_resp_compare #(
      .CHAIN_LEN (CHAIN_LEN),
      .PC_W      (PC_W)
   ) uCompare (
      .resp        (respFull),
      .expBits     (expCur),
      .popCnt      (popCnt),
      .anyMismatch (anyMismatch)
   );

   always_comb begin
      stateNext     = state;
      patIdxNext    = patIdx;
      numPatNext    = numPatR;
      bitCntNext    = bitCnt;
      stimSrNext    = stimSr;
      respSrNext    = respSr;
      expCurNext    = expCur;
      expNxtNext    = expNxt;
      failNext      = fail;
      cntNext       = mismatch_cnt;
      firstFailNext = first_fail;
      doCompare     = 1'b0;
      cmpIdx        = patIdx;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               failNext      = 1'b0;
               cntNext       = '0;
               firstFailNext = '0;
               patIdxNext    = '0;
               numPatNext    = (num_pat > MAX_PAT) ? MAX_PAT : num_pat;
               stateNext     = (num_pat == '0) ? DONE : FETCH;
            end
         end
         FETCH: stateNext = LOAD;
         LOAD: begin
            stimSrNext = mem_data[STIM_MSB:STIM_LSB];
            expNxtNext = mem_data[EXP_MSB:EXP_LSB];
            bitCntNext = '0;
            stateNext  = SHIFT;
         end
         SHIFT: begin
            stimSrNext = stimSr >> 1;
            respSrNext = respFull[CHAIN_LEN-1:1];
            bitCntNext = lastBit ? '0 : bitCnt + BIT_W'(1);
            if (lastBit) begin
               doCompare  = (patIdx != '0);
               cmpIdx     = patIdx - ADDR_W'(1);
               expCurNext = expNxt;
               stateNext  = CAPTURE;
            end
         end
         CAPTURE: begin
            bitCntNext = '0;
            if (({1'b0, patIdx} + NP_W'(1)) < numPatR) begin
               patIdxNext = patIdx + ADDR_W'(1);
               stateNext  = FETCH;
            end else begin
               stateNext = UNLOAD;
            end
         end
         UNLOAD: begin
            respSrNext = respFull[CHAIN_LEN-1:1];
            bitCntNext = lastBit ? '0 : bitCnt + BIT_W'(1);
            if (lastBit) begin
               doCompare = 1'b1;
               stateNext = DONE;
            end
         end
         default: stateNext = IDLE;
      endcase

      // Accumulate the previous pattern's result; counter saturates
      if (doCompare) begin
         cntNext = (cntSum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cntSum);
         if (anyMismatch) begin
            failNext = 1'b1;
            if (!fail) firstFailNext = cmpIdx;
         end
      end

      // Outputs are registered, so they follow the state being entered
      memRdNext   = (stateNext == FETCH);
      memAddrNext = (stateNext == FETCH) ? patIdxNext : mem_addr;
      scanEnNext  = (stateNext == SHIFT) || (stateNext == UNLOAD);
      scanInNext  = (stateNext == SHIFT) ? stimSrNext[0] : 1'b0;
      busyNext    = (stateNext != IDLE) && (stateNext != DONE);
      doneNext    = (stateNext == DONE);
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         patIdx       <= '0;
         numPatR      <= '0;
         bitCnt       <= '0;
         stimSr       <= '0;
         respSr       <= '0;
         expCur       <= '0;
         expNxt       <= '0;
         mem_addr     <= '0;
         mem_rd       <= 1'b0;
         scan_en      <= 1'b0;
         scan_in      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         fail         <= 1'b0;
         mismatch_cnt <= '0;
         first_fail   <= '0;
      end else begin
         state        <= stateNext;
         patIdx       <= patIdxNext;
         numPatR      <= numPatNext;
         bitCnt       <= bitCntNext;
         stimSr       <= stimSrNext;
         respSr       <= respSrNext;
         expCur       <= expCurNext;
         expNxt       <= expNxtNext;
         mem_addr     <= memAddrNext;
         mem_rd       <= memRdNext;
         scan_en      <= scanEnNext;
         scan_in      <= scanInNext;
         busy         <= busyNext;
         done         <= doneNext;
         fail         <= failNext;
         mismatch_cnt <= cntNext;
         first_fail   <= firstFailNext;
      end
   end

endmodule
